// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types: forwarding-select encodings, hazard controller states, default widths.
package pipe_pkg;

    localparam int R_SIZE_DEF = 3;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_t;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } hc_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// READ/EX hazard status in, pipeline control and forwarding selects out.
interface hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int R_SIZE = R_SIZE_DEF,
    parameter int CNT_W  = 16
);
    logic [R_SIZE-1:0] addr_op1_rd;
    logic [R_SIZE-1:0] addr_op2_rd;
    logic              op1_used;
    logic              op2_used;
    logic [R_SIZE-1:0] dest_ex;
    logic              reg_we_ex;
    logic              load_ex;
    logic [R_SIZE-1:0] dest_wb;
    logic              reg_we_wb;
    logic              jump_ex;
    logic              freeze;
    logic              clear_ex;
    logic              flush;
    fwd_t              fwd_sel1;
    fwd_t              fwd_sel2;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output addr_op1_rd, addr_op2_rd, op1_used, op2_used,
               dest_ex, reg_we_ex, load_ex, dest_wb, reg_we_wb, jump_ex,
        input  freeze, clear_ex, flush, fwd_sel1, fwd_sel2, stall_cnt
    );

    modport slave (
        input  addr_op1_rd, addr_op2_rd, op1_used, op2_used,
               dest_ex, reg_we_ex, load_ex, dest_wb, reg_we_wb, jump_ex,
        output freeze, clear_ex, flush, fwd_sel1, fwd_sel2, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Forwarding select for one operand; combinational, EX result beats WB result.
module fwd_sel_unit
    import pipe_pkg::*;
#(
    parameter int R_SIZE = R_SIZE_DEF
) (
    input  logic              en_i,
    input  logic [R_SIZE-1:0] addr_i,
    input  logic              used_i,
    input  logic [R_SIZE-1:0] dest_ex_i,
    input  logic              we_ex_i,
    input  logic              load_ex_i,
    input  logic [R_SIZE-1:0] dest_wb_i,
    input  logic              we_wb_i,
    output fwd_t              sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (en_i && used_i) begin
            // A load in EX has no result yet; the stall covers that case.
            if (we_ex_i && !load_ex_i && (addr_i == dest_ex_i)) begin
                sel_o = FWD_EX;
            end else if (we_wb_i && (addr_i == dest_wb_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// READ/EX hazard controller: load-use freeze for MEM_LAT cycles, jump flush, operand forwarding.
// Controls are combinational (zero latency) and forced low in reset; stall counter is registered.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int R_SIZE  = R_SIZE_DEF,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hc
);

    localparam int              WC_W    = $clog2(MEM_LAT + 1);
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(MEM_LAT - 1);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

    hc_state_t        state_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lu_haz;
    logic freeze;
    logic clear_ex;
    logic flush;
    fwd_t sel1;
    fwd_t sel2;

    always_comb begin
        lu_haz = hc.load_ex & hc.reg_we_ex &
                 ((hc.op1_used & (hc.addr_op1_rd == hc.dest_ex)) |
                  (hc.op2_used & (hc.addr_op2_rd == hc.dest_ex)));
    end

    always_comb begin
        freeze   = 1'b0;
        clear_ex = 1'b0;
        flush    = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (hc.jump_ex) begin
                        flush = 1'b1;
                    end else if (lu_haz) begin
                        freeze   = 1'b1;
                        clear_ex = 1'b1;
                    end
                end
                // EX holds a bubble here, so a jump indication cannot be real.
                LOAD_WAIT: begin
                    freeze   = 1'b1;
                    clear_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hc.jump_ex && lu_haz && (MEM_LAT > 1)) begin
                        state_q    <= LOAD_WAIT;
                        wait_cnt_q <= WC_LOAD;
                    end
                end
                LOAD_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - WC_ONE;
                    if (wait_cnt_q == WC_ONE) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    fwd_sel_unit #(.R_SIZE(R_SIZE)) u_fwd1 (
        .en_i      (rst),
        .addr_i    (hc.addr_op1_rd),
        .used_i    (hc.op1_used),
        .dest_ex_i (hc.dest_ex),
        .we_ex_i   (hc.reg_we_ex),
        .load_ex_i (hc.load_ex),
        .dest_wb_i (hc.dest_wb),
        .we_wb_i   (hc.reg_we_wb),
        .sel_o     (sel1)
    );

    fwd_sel_unit #(.R_SIZE(R_SIZE)) u_fwd2 (
        .en_i      (rst),
        .addr_i    (hc.addr_op2_rd),
        .used_i    (hc.op2_used),
        .dest_ex_i (hc.dest_ex),
        .we_ex_i   (hc.reg_we_ex),
        .load_ex_i (hc.load_ex),
        .dest_wb_i (hc.dest_wb),
        .we_wb_i   (hc.reg_we_wb),
        .sel_o     (sel2)
    );

    assign hc.freeze    = freeze;
    assign hc.clear_ex  = clear_ex;
    assign hc.flush     = flush;
    assign hc.fwd_sel1  = sel1;
    assign hc.fwd_sel2  = sel2;
    assign hc.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_LAT=2, CNT_W=16.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int R_SIZE  = 3;
    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.R_SIZE(R_SIZE), .CNT_W(CNT_W)) hc ();

    hazard_ctrl #(.R_SIZE(R_SIZE), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle_in();
        hc.addr_op1_rd = '0;
        hc.addr_op2_rd = '0;
        hc.op1_used    = 1'b0;
        hc.op2_used    = 1'b0;
        hc.dest_ex     = '0;
        hc.reg_we_ex   = 1'b0;
        hc.load_ex     = 1'b0;
        hc.dest_wb     = '0;
        hc.reg_we_wb   = 1'b0;
        hc.jump_ex     = 1'b0;
    endtask

    // Load writing d in EX, READ uses d as op1.
    task automatic load_use(input logic [R_SIZE-1:0] d);
        idle_in();
        hc.load_ex     = 1'b1;
        hc.reg_we_ex   = 1'b1;
        hc.dest_ex     = d;
        hc.addr_op1_rd = d;
        hc.op1_used    = 1'b1;
    endtask

    // Bubble in EX, READ still holding a reader of d.
    task automatic bubble(input logic [R_SIZE-1:0] d);
        idle_in();
        hc.addr_op1_rd = d;
        hc.op1_used    = 1'b1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic fz, input logic clr, input logic fl);
        chk({tag, ".freeze"},   32'(hc.freeze),   32'(fz));
        chk({tag, ".clear_ex"}, 32'(hc.clear_ex), 32'(clr));
        chk({tag, ".flush"},    32'(hc.flush),    32'(fl));
    endtask

    initial begin
        idle_in();
        // Reset: outputs forced low even with hazard, jump and WB match present.
        load_use(3'd3);
        hc.jump_ex   = 1'b1;
        hc.reg_we_wb = 1'b1;
        hc.dest_wb   = 3'd3;
        @(negedge clk);
        ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.fwd1", 32'(hc.fwd_sel1), 32'h0);
        chk("rst.cnt",  32'(hc.stall_cnt), 32'h0);
        idle_in();
        next_cyc();
        rst = 1'b1;

        // Load-use on r3: two freeze cycles, then WB forwarding.
        next_cyc();
        load_use(3'd3);
        @(negedge clk);
        ctl("lu.c0", 1'b1, 1'b1, 1'b0);
        chk("lu.c0.fwd1", 32'(hc.fwd_sel1), 32'h0);
        chk("lu.c0.cnt",  32'(hc.stall_cnt), 32'd0);
        next_cyc();
        bubble(3'd3);
        hc.jump_ex = 1'b1;
        @(negedge clk);
        ctl("lu.c1", 1'b1, 1'b1, 1'b0);
        chk("lu.c1.cnt", 32'(hc.stall_cnt), 32'd1);
        next_cyc();
        bubble(3'd3);
        hc.reg_we_wb = 1'b1;
        hc.dest_wb   = 3'd3;
        @(negedge clk);
        ctl("lu.c2", 1'b0, 1'b0, 1'b0);
        chk("lu.c2.fwd1", 32'(hc.fwd_sel1), 32'h2);
        chk("lu.c2.cnt",  32'(hc.stall_cnt), 32'd2);

        // Forwarding priority on op2.
        next_cyc();
        idle_in();
        hc.reg_we_ex   = 1'b1;
        hc.dest_ex     = 3'd5;
        hc.reg_we_wb   = 1'b1;
        hc.dest_wb     = 3'd5;
        hc.addr_op2_rd = 3'd5;
        hc.op2_used    = 1'b1;
        hc.addr_op1_rd = 3'd5;
        #1;
        chk("fwd.ex_wins", 32'(hc.fwd_sel2), 32'h1);
        chk("fwd.op1_unused", 32'(hc.fwd_sel1), 32'h0);
        chk("fwd.no_freeze", 32'(hc.freeze), 32'h0);
        hc.reg_we_ex = 1'b0;
        #1;
        chk("fwd.wb", 32'(hc.fwd_sel2), 32'h2);
        hc.op2_used = 1'b0;
        #1;
        chk("fwd.unused", 32'(hc.fwd_sel2), 32'h0);
        idle_in();
        hc.reg_we_ex = 1'b1;
        hc.dest_ex   = 3'd0;
        hc.op1_used  = 1'b1;
        hc.reg_we_wb = 1'b1;
        hc.dest_wb   = 3'd6;
        hc.addr_op2_rd = 3'd6;
        hc.op2_used  = 1'b1;
        #1;
        chk("fwd.r0_ex", 32'(hc.fwd_sel1), 32'h1);
        chk("fwd.op2_wb", 32'(hc.fwd_sel2), 32'h2);

        // Jump beats a simultaneous load-use hazard.
        next_cyc();
        load_use(3'd2);
        hc.jump_ex = 1'b1;
        @(negedge clk);
        ctl("jmp.c0", 1'b0, 1'b0, 1'b1);
        next_cyc();
        idle_in();
        @(negedge clk);
        ctl("jmp.c1", 1'b0, 1'b0, 1'b0);
        chk("jmp.cnt", 32'(hc.stall_cnt), 32'd2);

        // Reset pulse during LOAD_WAIT.
        next_cyc();
        load_use(3'd4);
        @(negedge clk);
        chk("mid.c0.freeze", 32'(hc.freeze), 32'h1);
        next_cyc();
        bubble(3'd4);
        #1;
        chk("mid.c1.freeze", 32'(hc.freeze), 32'h1);
        chk("mid.c1.cnt", 32'(hc.stall_cnt), 32'd3);
        rst = 1'b0;
        #1;
        chk("mid.rst.freeze", 32'(hc.freeze), 32'h0);
        chk("mid.rst.clear", 32'(hc.clear_ex), 32'h0);
        chk("mid.rst.cnt", 32'(hc.stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cyc();
        bubble(3'd4);
        @(negedge clk);
        chk("mid.after.freeze", 32'(hc.freeze), 32'h0);
        chk("mid.after.cnt", 32'(hc.stall_cnt), 32'd0);

        // Back-to-back hazards: four continuous freeze cycles.
        next_cyc();
        load_use(3'd1);
        @(negedge clk);
        chk("b2b.c0", 32'(hc.freeze), 32'h1);
        next_cyc();
        bubble(3'd1);
        @(negedge clk);
        chk("b2b.c1", 32'(hc.freeze), 32'h1);
        next_cyc();
        load_use(3'd1);
        @(negedge clk);
        chk("b2b.c2", 32'(hc.freeze), 32'h1);
        next_cyc();
        bubble(3'd1);
        @(negedge clk);
        chk("b2b.c3", 32'(hc.freeze), 32'h1);
        next_cyc();
        idle_in();
        @(negedge clk);
        chk("b2b.c4", 32'(hc.freeze), 32'h0);
        chk("b2b.cnt", 32'(hc.stall_cnt), 32'd4);

        // Saturation: hold a hazard so freeze stays high every cycle.
        next_cyc();
        load_use(3'd7);
        repeat (32'hFFFE - 4) @(posedge clk);
        #1;
        chk("sat.fffe", 32'(hc.stall_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("sat.ffff", 32'(hc.stall_cnt), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("sat.hold", 32'(hc.stall_cnt), 32'hFFFF);
        chk("sat.freeze", 32'(hc.freeze), 32'h1);
        idle_in();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
